mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 564 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction-fetch and data sides share one memory port.
// Round-robin grant on collision, registered handshakes, and a BUSY timeout that raises a sticky bus_err.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ack,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_stall,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // The counter only has to reach TIMEOUT-1: the cycle it sits there is the last BUSY cycle.
    localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] busy_cnt;
    logic             gnt_d;
    logic             last_d;
    logic             pick_d;
    logic             done;

    // On a collision the data side wins unless it was the side granted last.
    assign pick_d    = dc_req & (~ic_req | ~last_d);
    assign done      = mem_ready | (busy_cnt == CNT_LAST);
    assign mem_stall = (ic_req & ~ic_ack) | (dc_req & ~dc_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy_cnt  <= '0;
            gnt_d     <= 1'b0;
            last_d    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ic_rdata  <= '0;
            dc_rdata  <= '0;
            ic_ack    <= 1'b0;
            dc_ack    <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            ic_ack <= 1'b0;
            dc_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        state    <= BUSY;
                        mem_req  <= 1'b1;
                        busy_cnt <= '0;
                        gnt_d    <= pick_d;
                        last_d   <= pick_d;
                        if (pick_d) begin
                            mem_we    <= dc_we;
                            mem_addr  <= dc_addr;
                            mem_wdata <= dc_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= ic_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (done) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_ready) begin
                            bus_err <= 1'b1;
                        end
                        // A timed-out read returns zero; writes never touch the read register.
                        if (gnt_d) begin
                            dc_ack <= 1'b1;
                            if (!mem_we) begin
                                dc_rdata <= mem_ready ? mem_rdata : '0;
                            end
                        end else begin
                            ic_ack   <= 1'b1;
                            ic_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory slave plus scenario tasks and a
// randomized run checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = '0;
    logic [31:0] ic_rdata;
    logic        ic_ack;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [31:0] dc_addr = '0;
    logic [31:0] dc_wdata = '0;
    logic [31:0] dc_rdata;
    logic        dc_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        mem_stall;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ack(ic_ack),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ack(dc_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Memory slave: answers after slave_lat cycles of mem_req (0 = never), logs each access.
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    int          slave_lat   = 1;
    bit          slave_rand  = 1'b0;
    logic [31:0] slave_fixed = '0;
    bit          spurious    = 1'b0;
    int          busy_n      = 0;
    int          unstable    = 0;
    logic [31:0] last_rdata  = '0;
    acc_t        first_acc;
    acc_t        log_q[$];

    always @(negedge clk) begin
        if (mem_req !== 1'b1) begin
            busy_n    = 0;
            mem_ready = spurious;
            mem_rdata = $urandom;
        end else begin
            busy_n++;
            if (busy_n == 1) begin
                first_acc = '{mem_addr, mem_we, mem_wdata};
                log_q.push_back(first_acc);
            end else if (mem_addr !== first_acc.addr || mem_we !== first_acc.we ||
                         mem_wdata !== first_acc.wdata) begin
                unstable++;
            end
            if (busy_n == slave_lat) begin
                last_rdata = slave_rand ? $urandom : slave_fixed;
                mem_ready  = 1'b1;
                mem_rdata  = last_rdata;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        ic_req = 1'b0;
        dc_req = 1'b0;
        dc_we  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Advances until either ack is seen or 20 cycles pass; callers check the ack.
    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (ic_ack !== 1'b1 && dc_ack !== 1'b1 && cyc < 20);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({mem_req, mem_we, ic_ack, dc_ack, bus_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, ic_ack, dc_ack, bus_err});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, ic_rdata, dc_rdata} !== 128'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, ic_rdata, dc_rdata});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_iread();
        int req_cycles;
        int bad;
        apply_reset();
        slave_lat   = 3;
        slave_rand  = 1'b0;
        slave_fixed = 32'h00500093;
        ic_req  = 1'b1;
        ic_addr = 32'h100;
        #1;
        n_tests++;
        if (mem_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL iread_stall_pending: got %b expected 1", mem_stall);
        end
        tick();
        req_cycles = 0;
        bad = 0;
        for (int c = 1; c <= 3; c++) begin
            if (mem_req === 1'b1) req_cycles++;
            if (mem_addr !== 32'h100 || mem_we !== 1'b0 || ic_ack !== 1'b0) bad++;
            tick();
        end
        n_tests++;
        if (req_cycles !== 3) begin
            n_fail++;
            $display("FAIL iread_req_cycles: got %0d expected 3", req_cycles);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL iread_busy_bus: got %0d bad cycles expected 0", bad);
        end
        n_tests++;
        if ({ic_ack, mem_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL iread_ack_cycle4: got ack/req %b expected 10", {ic_ack, mem_req});
        end
        n_tests++;
        if (ic_rdata !== 32'h00500093) begin
            n_fail++;
            $display("FAIL iread_rdata: got %h expected 00500093", ic_rdata);
        end
        n_tests++;
        if (mem_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL iread_stall_ack: got %b expected 0", mem_stall);
        end
        ic_req = 1'b0;
        tick();
        n_tests++;
        if (ic_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL iread_ack_width: got %b expected 0", ic_ack);
        end
    endtask

    task automatic test_collision();
        int cyc;
        logic [1:0] exp_ack;
        logic [31:0] exp_addr;
        acc_t e;
        apply_reset();
        slave_lat  = 2;
        slave_rand = 1'b1;
        log_q.delete();
        ic_req  = 1'b1;
        ic_addr = 32'h0A0;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 32'h0B0;
        for (int k = 0; k < 3; k++) begin
            wait_ack(cyc);
            exp_ack = (k % 2 == 0) ? 2'b10 : 2'b01;
            n_tests++;
            if ({dc_ack, ic_ack} !== exp_ack) begin
                n_fail++;
                $display("FAIL collision_order_%0d: got dc/ic ack %b expected %b", k, {dc_ack, ic_ack}, exp_ack);
            end
            n_tests++;
            if (((k % 2 == 0) ? dc_rdata : ic_rdata) !== last_rdata) begin
                n_fail++;
                $display("FAIL collision_rdata_%0d: got %h expected %h", k,
                         (k % 2 == 0) ? dc_rdata : ic_rdata, last_rdata);
            end
            if (k == 2) begin
                ic_req = 1'b0;
                dc_req = 1'b0;
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            exp_addr = (k % 2 == 0) ? 32'h0B0 : 32'h0A0;
            n_tests++;
            if (log_q.size() == 0) begin
                n_fail++;
                $display("FAIL collision_log_%0d: got no access expected addr %h", k, exp_addr);
            end else begin
                e = log_q.pop_front();
                if (e.addr !== exp_addr || e.we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL collision_log_%0d: got addr %h we %b expected %h we 0", k, e.addr, e.we, exp_addr);
                end
            end
        end
    endtask

    task automatic test_dwrite();
        int cyc;
        int bad;
        apply_reset();
        slave_rand  = 1'b0;
        slave_lat   = 1;
        slave_fixed = 32'h12345678;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 32'h40;
        wait_ack(cyc);
        n_tests++;
        if (dc_ack !== 1'b1 || dc_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL dwrite_preread: got ack %b rdata %h expected 1 12345678", dc_ack, dc_rdata);
        end
        dc_req = 1'b0;
        tick();
        slave_lat   = 3;
        slave_fixed = 32'hCAFEF00D;
        unstable    = 0;
        dc_req   = 1'b1;
        dc_we    = 1'b1;
        dc_addr  = 32'h2000;
        dc_wdata = 32'hDEADBEEF;
        tick();
        cyc = 0;
        bad = 0;
        while (dc_ack !== 1'b1 && cyc < 20) begin
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'hDEADBEEF) bad++;
            cyc++;
            tick();
        end
        n_tests++;
        if (cyc !== 3 || bad !== 0 || unstable !== 0) begin
            n_fail++;
            $display("FAIL dwrite_bus: got %0d busy cycles %0d bad %0d unstable expected 3 0 0", cyc, bad, unstable);
        end
        n_tests++;
        if (dc_ack !== 1'b1 || ic_ack !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL dwrite_ack: got dc %b ic %b we %b expected 1 0 0", dc_ack, ic_ack, mem_we);
        end
        n_tests++;
        if (dc_rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL dwrite_rdata_kept: got %h expected 12345678", dc_rdata);
        end
        dc_req = 1'b0;
        dc_we  = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int cyc;
        int req_cycles;
        apply_reset();
        slave_rand  = 1'b0;
        slave_lat   = 1;
        slave_fixed = 32'h11112222;
        ic_req  = 1'b1;
        ic_addr = 32'h200;
        wait_ack(cyc);
        n_tests++;
        if (ic_rdata !== 32'h11112222 || bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pre: got rdata %h err %b expected 11112222 0", ic_rdata, bus_err);
        end
        ic_req = 1'b0;
        tick();
        slave_lat = 0;
        ic_req  = 1'b1;
        ic_addr = 32'h300;
        tick();
        req_cycles = 0;
        while (ic_ack !== 1'b1 && req_cycles < 20) begin
            if (mem_req === 1'b1) req_cycles++;
            tick();
        end
        n_tests++;
        if (req_cycles !== TO) begin
            n_fail++;
            $display("FAIL timeout_busy_cycles: got %0d expected %0d", req_cycles, TO);
        end
        n_tests++;
        if (ic_ack !== 1'b1 || ic_rdata !== 32'h0 || bus_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_resp: got ack %b rdata %h err %b expected 1 0 1", ic_ack, ic_rdata, bus_err);
        end
        ic_req = 1'b0;
        tick();
        n_tests++;
        if (ic_ack !== 1'b0 || bus_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_after: got ack %b err %b expected 0 1", ic_ack, bus_err);
        end
        slave_lat   = 2;
        slave_fixed = 32'h0BADF00D;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 32'h400;
        wait_ack(cyc);
        n_tests++;
        if (dc_ack !== 1'b1 || dc_rdata !== 32'h0BADF00D || bus_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got ack %b rdata %h err %b expected 1 0badf00d 1", dc_ack, dc_rdata, bus_err);
        end
        dc_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        int cyc;
        int acks;
        slave_lat = 0;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 32'h80;
        tick();
        tick();
        n_tests++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstbusy_pre: got mem_req %b expected 1", mem_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({mem_req, mem_we, ic_ack, dc_ack, bus_err} !== 5'b0 ||
            {mem_addr, mem_wdata, ic_rdata, dc_rdata} !== 128'b0) begin
            n_fail++;
            $display("FAIL rstbusy_immediate: got ctrl %b data %h expected 0 0",
                     {mem_req, mem_we, ic_ack, dc_ack, bus_err}, {mem_addr, mem_wdata, ic_rdata, dc_rdata});
        end
        dc_req = 1'b0;
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ic_ack === 1'b1 || dc_ack === 1'b1 || mem_req === 1'b1) acks++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ic_ack === 1'b1 || dc_ack === 1'b1 || mem_req === 1'b1) acks++;
        end
        n_tests++;
        if (acks !== 0) begin
            n_fail++;
            $display("FAIL rstbusy_no_ack: got %0d active cycles expected 0", acks);
        end
        slave_rand  = 1'b0;
        slave_lat   = 2;
        slave_fixed = 32'h55AA55AA;
        ic_req  = 1'b1;
        ic_addr = 32'h500;
        wait_ack(cyc);
        n_tests++;
        if (ic_ack !== 1'b1 || ic_rdata !== 32'h55AA55AA || cyc !== 3) begin
            n_fail++;
            $display("FAIL rstbusy_recover: got ack %b rdata %h after %0d expected 1 55aa55aa after 3", ic_ack, ic_rdata, cyc);
        end
        ic_req = 1'b0;
        tick();
    endtask

    task automatic test_dropped_req();
        int cyc;
        int stall_bad;
        slave_rand  = 1'b0;
        slave_lat   = 3;
        slave_fixed = 32'h0F0F0F0F;
        ic_req  = 1'b1;
        ic_addr = 32'h104;
        tick();
        ic_req = 1'b0;
        #1;
        stall_bad = 0;
        cyc = 0;
        while (ic_ack !== 1'b1 && cyc < 20) begin
            if (mem_stall !== 1'b0) stall_bad++;
            cyc++;
            tick();
        end
        n_tests++;
        if (ic_ack !== 1'b1 || ic_rdata !== 32'h0F0F0F0F) begin
            n_fail++;
            $display("FAIL dropped_ack: got ack %b rdata %h expected 1 0f0f0f0f", ic_ack, ic_rdata);
        end
        n_tests++;
        if (stall_bad !== 0 || mem_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL dropped_stall: got %0d stalled cycles expected 0", stall_bad);
        end
        tick();
        n_tests++;
        if (ic_ack !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL dropped_idle: got ack %b req %b expected 0 0", ic_ack, mem_req);
        end
    endtask

    task automatic test_ready_idle();
        int bad;
        int cyc;
        spurious = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (mem_req !== 1'b0 || ic_ack !== 1'b0 || dc_ack !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL ready_idle: got %0d active cycles expected 0", bad);
        end
        slave_rand  = 1'b0;
        slave_lat   = 2;
        slave_fixed = 32'h77778888;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 32'h600;
        wait_ack(cyc);
        n_tests++;
        if (dc_ack !== 1'b1 || cyc !== 3 || dc_rdata !== 32'h77778888) begin
            n_fail++;
            $display("FAIL ready_idle_latency: got ack %b after %0d rdata %h expected 1 after 3 77778888", dc_ack, cyc, dc_rdata);
        end
        dc_req   = 1'b0;
        spurious = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int cyc;
        int pat;
        bit pend_i;
        bit pend_d;
        bit exp_d;
        bit m_last_d;
        bit w_we;
        logic [31:0] m_ic_rd;
        logic [31:0] m_dc_rd;
        logic [31:0] exp_addr;
        acc_t e;
        apply_reset();
        log_q.delete();
        slave_rand = 1'b1;
        m_last_d = 1'b0;
        m_ic_rd  = '0;
        m_dc_rd  = '0;
        for (int it = 0; it < 40; it++) begin
            pat    = $urandom_range(1, 3);
            pend_i = pat[0];
            pend_d = pat[1];
            ic_addr  = $urandom;
            dc_addr  = $urandom;
            dc_wdata = $urandom;
            w_we     = $urandom_range(0, 1) == 1;
            dc_we    = w_we;
            ic_req   = pend_i;
            dc_req   = pend_d;
            slave_lat = $urandom_range(1, TO - 1);
            while (pend_i || pend_d) begin
                exp_d = pend_d && (!pend_i || !m_last_d);
                wait_ack(cyc);
                n_tests++;
                if ({dc_ack, ic_ack} !== {exp_d, !exp_d}) begin
                    n_fail++;
                    $display("FAIL rand_grant_%0d: got dc/ic ack %b expected %b", it, {dc_ack, ic_ack}, {exp_d, !exp_d});
                end
                exp_addr = exp_d ? dc_addr : ic_addr;
                n_tests++;
                if (log_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_access_%0d: got no access expected addr %h", it, exp_addr);
                end else begin
                    e = log_q.pop_front();
                    if (e.addr !== exp_addr || e.we !== (exp_d & w_we) ||
                        (exp_d && w_we && e.wdata !== dc_wdata)) begin
                        n_fail++;
                        $display("FAIL rand_access_%0d: got addr %h we %b wdata %h expected %h we %b", it,
                                 e.addr, e.we, e.wdata, exp_addr, exp_d & w_we);
                    end
                end
                if (!exp_d) m_ic_rd = last_rdata;
                else if (!w_we) m_dc_rd = last_rdata;
                n_tests++;
                if (ic_rdata !== m_ic_rd || dc_rdata !== m_dc_rd) begin
                    n_fail++;
                    $display("FAIL rand_rdata_%0d: got ic %h dc %h expected ic %h dc %h", it, ic_rdata, dc_rdata, m_ic_rd, m_dc_rd);
                end
                m_last_d = exp_d;
                if (exp_d) begin
                    pend_d = 1'b0;
                    dc_req = 1'b0;
                end else begin
                    pend_i = 1'b0;
                    ic_req = 1'b0;
                end
                slave_lat = $urandom_range(1, TO - 1);
                tick();
            end
        end
        n_tests++;
        if (bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_bus_err: got %b expected 0", bus_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_iread();
        test_collision();
        test_dwrite();
        test_timeout();
        test_reset_mid_busy();
        test_dropped_req();
        test_ready_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
